// File: rtl/pcie_ingress_pkg.sv
// Shared types and constants for the PCIe TLP ingress router.
// Poison checking is enabled by defining PCIE_INGRESS_POISON_CHECK_EN.
package pcie_ingress_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_REG_WR,
      S_CMD_WR,
      S_CPL,
      S_DROP
   } state_t;

   localparam logic [2:0] FMT_3DW_D = 3'b010;
   localparam logic [2:0] FMT_4DW_D = 3'b011;
   localparam logic [4:0] TYPE_MEM  = 5'b00000;
   localparam logic [4:0] TYPE_CPL  = 5'b01010;

   localparam logic [2:0] ERR_NONE   = 3'd0;
   localparam logic [2:0] ERR_ADDR   = 3'd1;
   localparam logic [2:0] ERR_BUF    = 3'd2;
   localparam logic [2:0] ERR_MALF   = 3'd3;
   localparam logic [2:0] ERR_SHORT  = 3'd4;
   localparam logic [2:0] ERR_LONG   = 3'd5;
   localparam logic [2:0] ERR_POISON = 3'd6;

   localparam int FMT_HI   = 31;
   localparam int FMT_LO   = 29;
   localparam int TYPE_HI  = 28;
   localparam int TYPE_LO  = 24;
   localparam int EP_BIT   = 14;
   localparam int LEN_HI   = 9;
   localparam int LEN_LO   = 0;
   localparam int TAG_HI   = 15;
   localparam int TAG_LO   = 8;
   localparam int LADDR_HI = 6;
   localparam int LADDR_LO = 0;

endpackage

// File: rtl/pcie_ingress_hdr_decode.sv
// Combinational TLP header field decoder (3DW/4DW MWr and CplD).
// Used by pcie_ingress_router; no configuration macros.
module pcie_ingress_hdr_decode
   import pcie_ingress_pkg::*;
(
   input  logic [31:0] hdr0,
   input  logic [31:0] hdr2,
   input  logic [31:0] hdr3,
   output logic [2:0]  hdr_len,
   output logic        is_mwr,
   output logic        is_cpld,
   output logic        poisoned,
   output logic [10:0] length_dw,
   output logic [31:0] dw_addr,
   output logic [7:0]  tag,
   output logic [6:0]  lower_addr
);

   logic [2:0] fmt;
   logic [4:0] typ;
   logic [9:0] len;
   logic       unused_bits;

   assign fmt = hdr0[FMT_HI:FMT_LO];
   assign typ = hdr0[TYPE_HI:TYPE_LO];
   assign len = hdr0[LEN_HI:LEN_LO];

   assign hdr_len  = fmt[0] ? 3'd4 : 3'd3;
   assign is_mwr   = (fmt == FMT_3DW_D || fmt == FMT_4DW_D)
                     && typ == TYPE_MEM;
   assign is_cpld  = (fmt == FMT_3DW_D) && typ == TYPE_CPL;
   assign poisoned = hdr0[EP_BIT];

   // A zero length field encodes the maximum of 1024 DW
   assign length_dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};

   assign dw_addr    = fmt[0] ? {2'b00, hdr3[31:2]}
                              : {2'b00, hdr2[31:2]};
   assign tag        = hdr2[TAG_HI:TAG_LO];
   assign lower_addr = hdr2[LADDR_HI:LADDR_LO];

   assign unused_bits = ^{hdr0[23:15], hdr0[13:10], hdr3[1:0]};

endmodule

// File: rtl/pcie_ingress_router.sv
// Host-to-device TLP ingress parser: BAR0 writes to regs/commands, CplD to buffers.
// Define PCIE_INGRESS_POISON_CHECK_EN to drop poisoned (EP) TLPs with error 6.
module pcie_ingress_router
   import pcie_ingress_pkg::*;
#(
   parameter int NUM_REGS   = 8,
   parameter int CMD_OFFSET = 16,
   parameter int NUM_CH     = 2,
   parameter int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int BUF_AW     = 10
)(
   input  logic                     clk,
   input  logic                     rst,
   output logic                     o_axi_ingress_ready,
   input  logic [31:0]              i_axi_ingress_data,
   input  logic [3:0]               i_axi_ingress_keep,
   input  logic                     i_axi_ingress_last,
   input  logic                     i_axi_ingress_valid,
   input  logic [6:0]               i_bar_hit,
   input  logic [31:0]              i_control_addr_base,
   input  logic                     i_enable_data_path,
   input  logic [NUM_CH-1:0]        i_buf_rdy,
   input  logic [NUM_CH*BUF_AW-1:0] i_buf_base,
   output logic [NUM_REGS*32-1:0]   o_regs,
   output logic                     o_reg_write_stb,
   output logic [7:0]               o_reg_write_idx,
   output logic                     o_cmd_stb,
   output logic [7:0]               o_cmd_code,
   output logic [31:0]              o_cmd_value,
   output logic [NUM_CH-1:0]        o_buf_we,
   output logic [BUF_AW-1:0]        o_buf_addr,
   output logic [31:0]              o_buf_dat,
   output logic                     o_err_stb,
   output logic [2:0]               o_err_code
);

   localparam int CH_N = 1 << CH_BITS;
   localparam int RI_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] NR     = 32'(NUM_REGS);
   localparam logic [31:0] CMD_LO = 32'(CMD_OFFSET);
   localparam logic [31:0] CMD_HI = 32'(CMD_OFFSET + 256);

   state_t              state, nstate;
   logic [1:0]          cnt;
   logic [31:0]         h0, h2, h3, w0, w2, w3;
   logic                bar0, bar0_q;
   logic [31:0]         off, off_q, cmd_rel;
   logic                first_q;
   logic [CH_BITS-1:0]  ch, ch_q;
   logic [10:0]         len_q, k_q;
   logic                long_q;
   logic [BUF_AW-1:0]   addr_q, start;
   logic [31:0]         regs [NUM_REGS];
   logic [CH_N-1:0]     rdy_pad;
   logic [BUF_AW-1:0]   base_arr [CH_N];

   logic [2:0]          d_len;
   logic                d_mwr, d_cpld, d_ep;
   logic [10:0]         d_ldw;
   logic [31:0]         d_addr;
   logic [7:0]          d_tag;
   logic [6:0]          d_low;

   logic                beat, last, hdr_end, poison, cpl_wr;
   logic                err_now;
   logic [2:0]          err_val;
   logic                unused_ok;

   assign last                = i_axi_ingress_last;
   assign o_axi_ingress_ready = (state != S_IDLE);
   assign beat = i_axi_ingress_valid && o_axi_ingress_ready;

   // Decode sees the in-flight beat so dispatch lands on the last header DW
   assign w0 = (cnt == 2'd0) ? i_axi_ingress_data : h0;
   assign w2 = (cnt == 2'd2) ? i_axi_ingress_data : h2;
   assign w3 = (cnt == 2'd3) ? i_axi_ingress_data : h3;

   pcie_ingress_hdr_decode u_dec (
      .hdr0       (w0),
      .hdr2       (w2),
      .hdr3       (w3),
      .hdr_len    (d_len),
      .is_mwr     (d_mwr),
      .is_cpld    (d_cpld),
      .poisoned   (d_ep),
      .length_dw  (d_ldw),
      .dw_addr    (d_addr),
      .tag        (d_tag),
      .lower_addr (d_low)
   );

   assign bar0    = (cnt == 2'd0) ? i_bar_hit[0] : bar0_q;
   assign off     = d_addr - i_control_addr_base;
   assign ch      = d_tag[CH_BITS-1:0];
   assign start   = base_arr[ch] + BUF_AW'(d_low[6:2]);
   assign hdr_end = ({1'b0, cnt} == (d_len - 3'd1));
   assign cmd_rel = off_q - CMD_LO;
   assign cpl_wr  = (k_q < len_q);

   for (genvar g = 0; g < CH_N; g++) begin : g_ch
      if (g < NUM_CH) begin : g_real
         assign rdy_pad[g]  = i_buf_rdy[g];
         assign base_arr[g] = i_buf_base[g*BUF_AW +: BUF_AW];
      end else begin : g_pad
         assign rdy_pad[g]  = 1'b0;
         assign base_arr[g] = '0;
      end
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_regs
      assign o_regs[r*32 +: 32] = regs[r];
   end

`ifdef PCIE_INGRESS_POISON_CHECK_EN
   assign poison = d_ep;
`else
   assign poison = 1'b0;
`endif

   assign unused_ok = ^{i_axi_ingress_keep, i_bar_hit[6:1], d_tag,
                        d_low[1:0], d_ep, cmd_rel[31:8]};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate  = state;
      err_now = 1'b0;
      err_val = ERR_NONE;
      unique case (state)
         S_IDLE: if (i_axi_ingress_valid) nstate = S_HDR;
         S_HDR: if (beat) begin
            if (!hdr_end) begin
               if (last) begin
                  nstate  = S_IDLE;
                  err_now = 1'b1;
                  err_val = ERR_MALF;
               end
            end else begin
               nstate = last ? S_IDLE : S_DROP;
               if (poison) begin
                  err_now = 1'b1;
                  err_val = ERR_POISON;
               end else if (d_mwr && last) begin
                  err_now = 1'b1;
                  err_val = ERR_MALF;
               end else if (d_mwr && bar0) begin
                  if (off < NR) begin
                     nstate = S_REG_WR;
                  end else if (off >= CMD_LO && off < CMD_HI) begin
                     nstate = S_CMD_WR;
                  end else begin
                     err_now = 1'b1;
                     err_val = ERR_ADDR;
                  end
               end else if (d_cpld) begin
                  if (i_enable_data_path && rdy_pad[ch]) begin
                     if (!last) nstate = S_CPL;
                  end else begin
                     err_now = 1'b1;
                     err_val = ERR_BUF;
                  end
               end
            end
         end
         S_CPL: if (beat) begin
            if (last) nstate = S_IDLE;
            if (!cpl_wr) begin
               if (!long_q) begin
                  err_now = 1'b1;
                  err_val = ERR_LONG;
               end
            end else if (last && (k_q + 11'd1 < len_q)) begin
               err_now = 1'b1;
               err_val = ERR_SHORT;
            end
         end
         S_REG_WR, S_CMD_WR, S_DROP: begin
            if (beat && last) nstate = S_IDLE;
         end
         default: nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt             <= '0;
         h0              <= '0;
         h2              <= '0;
         h3              <= '0;
         bar0_q          <= 1'b0;
         off_q           <= '0;
         first_q         <= 1'b0;
         ch_q            <= '0;
         len_q           <= '0;
         k_q             <= '0;
         long_q          <= 1'b0;
         addr_q          <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         o_reg_write_stb <= 1'b0;
         o_reg_write_idx <= '0;
         o_cmd_stb       <= 1'b0;
         o_cmd_code      <= '0;
         o_cmd_value     <= '0;
         o_buf_we        <= '0;
         o_buf_addr      <= '0;
         o_buf_dat       <= '0;
         o_err_stb       <= 1'b0;
         o_err_code      <= '0;
      end else begin
         o_reg_write_stb <= 1'b0;
         o_cmd_stb       <= 1'b0;
         o_buf_we        <= '0;
         o_err_stb       <= 1'b0;
         if (err_now) begin
            o_err_stb  <= 1'b1;
            o_err_code <= err_val;
         end
         if (state == S_IDLE) cnt <= '0;
         if (state == S_HDR && beat) begin
            cnt <= cnt + 2'd1;
            case (cnt)
               2'd0:    h0 <= i_axi_ingress_data;
               2'd2:    h2 <= i_axi_ingress_data;
               2'd3:    h3 <= i_axi_ingress_data;
               default: ;
            endcase
            bar0_q  <= bar0;
            off_q   <= off;
            first_q <= 1'b1;
            ch_q    <= ch;
            len_q   <= d_ldw;
            k_q     <= '0;
            long_q  <= 1'b0;
            addr_q  <= start;
         end
         if (state == S_REG_WR && beat && off_q < NR) begin
            regs[off_q[RI_W-1:0]] <= i_axi_ingress_data;
            o_reg_write_stb       <= 1'b1;
            o_reg_write_idx       <= off_q[7:0];
            off_q                 <= off_q + 32'd1;
         end
         if (state == S_CMD_WR && beat && first_q) begin
            o_cmd_stb   <= 1'b1;
            o_cmd_code  <= cmd_rel[7:0];
            o_cmd_value <= i_axi_ingress_data;
            first_q     <= 1'b0;
         end
         if (state == S_CPL && beat) begin
            if (cpl_wr) begin
               o_buf_we[ch_q] <= 1'b1;
               o_buf_addr     <= addr_q;
               o_buf_dat      <= i_axi_ingress_data;
               addr_q         <= addr_q + 1'b1;
               k_q            <= k_q + 11'd1;
            end else begin
               long_q <= 1'b1;
            end
         end
      end
   end

endmodule
